// File: rtl/ysyx_24090012_lsu.sv
// Load/store unit between EXU and WBU: one word-bus transaction per load/store,
// aligned sign/zero-extended loads, pass-through of ALU results for everything else.
module ysyx_24090012_lsu #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exu_valid,
  output logic        exu_ready,
  input  logic [31:0] exu_addr,
  input  logic [31:0] exu_wdata,
  input  logic [31:0] exu_rd_data,
  input  logic [31:0] exu_inst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wbu_valid,
  input  logic        wbu_ready,
  output logic [31:0] wbu_rd_data,
  output logic [31:0] wbu_inst,
  output logic        lsu_err,
  output logic [31:0] ls_count
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned STB_W = 4;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        off_q, off_d;
  logic              is_mem_q, is_mem_d;
  logic              exu_ready_q, exu_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STB_W-1:0]  mem_wstrb_q, mem_wstrb_d;
  logic              wbu_valid_q, wbu_valid_d;
  logic [XLEN-1:0]   wbu_rd_data_q, wbu_rd_data_d;
  logic [XLEN-1:0]   wbu_inst_q, wbu_inst_d;
  logic              lsu_err_q, lsu_err_d;
  logic [XLEN-1:0]   ls_count_q, ls_count_d;

  // Decode of the instruction currently offered by the EXU
  logic [6:0]       opc_c;
  logic [2:0]       f3_c;
  logic             is_load_c, is_store_c, f3_ok_c, aligned_c, mem_ok_c;
  logic [STB_W-1:0] st_wstrb_c;
  logic [XLEN-1:0]  st_wdata_c;

  assign opc_c      = exu_inst[6:0];
  assign f3_c       = exu_inst[14:12];
  assign is_load_c  = (opc_c == OPC_LOAD);
  assign is_store_c = (opc_c == OPC_STORE);
  assign mem_ok_c   = (is_load_c || is_store_c) && f3_ok_c && aligned_c;

  always_comb begin
    f3_ok_c    = 1'b0;
    aligned_c  = 1'b1;
    st_wstrb_c = 4'b1111;
    st_wdata_c = exu_wdata;
    if (is_load_c) begin
      f3_ok_c = (f3_c inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end else if (is_store_c) begin
      f3_ok_c = (f3_c inside {3'b000, 3'b001, 3'b010});
    end
    case (f3_c[1:0])
      2'b00: begin
        st_wstrb_c = 4'b0001 << exu_addr[1:0];
        st_wdata_c = {4{exu_wdata[7:0]}};
      end
      2'b01: begin
        aligned_c  = ~exu_addr[0];
        st_wstrb_c = 4'b0011 << {exu_addr[1], 1'b0};
        st_wdata_c = {2{exu_wdata[15:0]}};
      end
      2'b10: aligned_c = (exu_addr[1:0] == 2'b00);
      default: ;
    endcase
  end

  // Load lane extraction and extension from the latched offset/funct3
  logic [7:0]      ld_byte_c;
  logic [15:0]     ld_half_c;
  logic [XLEN-1:0] ld_data_c;

  assign ld_byte_c = 8'(mem_rdata >> {off_q, 3'b000});
  assign ld_half_c = 16'(mem_rdata >> {off_q[1], 4'b0000});

  always_comb begin
    case (wbu_inst_q[14:12])
      3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b100:  ld_data_c = {24'b0, ld_byte_c};
      3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b101:  ld_data_c = {16'b0, ld_half_c};
      default: ld_data_c = mem_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    off_d         = off_q;
    is_mem_d      = is_mem_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    wbu_rd_data_d = wbu_rd_data_q;
    wbu_inst_d    = wbu_inst_q;
    lsu_err_d     = lsu_err_q;
    ls_count_d    = ls_count_q;

    case (state_q)
      S_IDLE: begin
        if (exu_valid) begin
          wbu_inst_d = exu_inst;
          off_d      = exu_addr[1:0];
          is_mem_d   = mem_ok_c;
          lsu_err_d  = (is_load_c || is_store_c) && !mem_ok_c;
          if (mem_ok_c) begin
            mem_we_d      = is_store_c;
            mem_addr_d    = {exu_addr[31:2], 2'b00};
            mem_wdata_d   = is_store_c ? st_wdata_c : '0;
            mem_wstrb_d   = is_store_c ? st_wstrb_c : '0;
            wbu_rd_data_d = '0;
            cnt_d         = '0;
            state_d       = S_REQ;
          end else begin
            wbu_rd_data_d = (is_load_c || is_store_c) ? '0 : exu_rd_data;
            state_d       = S_DONE;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == TO_LAST) begin
          lsu_err_d     = 1'b1;
          wbu_rd_data_d = '0;
          state_d       = S_DONE;
        end else if (mem_gnt) begin
          // A response arriving with the grant is not a response to this request
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid) begin
          wbu_rd_data_d = mem_we_q ? '0 : ld_data_c;
          state_d       = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          lsu_err_d     = 1'b1;
          wbu_rd_data_d = '0;
          state_d       = S_DONE;
        end
      end
      S_DONE: begin
        if (wbu_ready) begin
          if (is_mem_q && !lsu_err_q) ls_count_d = ls_count_q + XLEN'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    exu_ready_d = (state_d == S_IDLE);
    mem_req_d   = (state_d == S_REQ);
    wbu_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      off_q         <= '0;
      is_mem_q      <= 1'b0;
      exu_ready_q   <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= '0;
      wbu_valid_q   <= 1'b0;
      wbu_rd_data_q <= '0;
      wbu_inst_q    <= '0;
      lsu_err_q     <= 1'b0;
      ls_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      off_q         <= off_d;
      is_mem_q      <= is_mem_d;
      exu_ready_q   <= exu_ready_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      wbu_valid_q   <= wbu_valid_d;
      wbu_rd_data_q <= wbu_rd_data_d;
      wbu_inst_q    <= wbu_inst_d;
      lsu_err_q     <= lsu_err_d;
      ls_count_q    <= ls_count_d;
    end
  end

  assign exu_ready   = exu_ready_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;
  assign wbu_valid   = wbu_valid_q;
  assign wbu_rd_data = wbu_rd_data_q;
  assign wbu_inst    = wbu_inst_q;
  assign lsu_err     = lsu_err_q;
  assign ls_count    = ls_count_q;

endmodule

// File: tb/tb_ysyx_24090012_lsu.sv
// Directed bench for ysyx_24090012_lsu: one default-timeout instance and one
// with TIMEOUT_CYC=4 share all inputs.
module tb_ysyx_24090012_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid;
  logic [31:0] exu_addr, exu_wdata, exu_rd_data, exu_inst;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wbu_ready;

  logic        exu_ready, mem_req, mem_we, wbu_valid, lsu_err;
  logic [31:0] mem_addr, mem_wdata, wbu_rd_data, wbu_inst, ls_count;
  logic [3:0]  mem_wstrb;

  logic        t_exu_ready, t_mem_req, t_mem_we, t_wbu_valid, t_lsu_err;
  logic [31:0] t_mem_addr, t_mem_wdata, t_wbu_rd_data, t_wbu_inst, t_ls_count;
  logic [3:0]  t_mem_wstrb;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  ysyx_24090012_lsu dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready),
    .exu_addr(exu_addr), .exu_wdata(exu_wdata), .exu_rd_data(exu_rd_data), .exu_inst(exu_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wbu_valid(wbu_valid), .wbu_ready(wbu_ready), .wbu_rd_data(wbu_rd_data),
    .wbu_inst(wbu_inst), .lsu_err(lsu_err), .ls_count(ls_count)
  );

  ysyx_24090012_lsu #(.TIMEOUT_CYC(4)) dut_to (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(t_exu_ready),
    .exu_addr(exu_addr), .exu_wdata(exu_wdata), .exu_rd_data(exu_rd_data), .exu_inst(exu_inst),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_wstrb(t_mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wbu_valid(t_wbu_valid), .wbu_ready(wbu_ready), .wbu_rd_data(t_wbu_rd_data),
    .wbu_inst(t_wbu_inst), .lsu_err(t_lsu_err), .ls_count(t_ls_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accepting edge
  task automatic issue(input logic [31:0] inst, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd);
    exu_valid = 1'b1; exu_inst = inst; exu_addr = addr; exu_wdata = wdata; exu_rd_data = rd;
    tick();
    exu_valid = 1'b0;
  endtask

  task automatic gnt_then_rsp(input logic [31:0] rdata);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic retire();
    wbu_ready = 1'b1;
    tick();
    wbu_ready = 1'b0;
  endtask

  localparam logic [31:0] I_ADDI = 32'h00100093;
  localparam logic [31:0] I_LB   = 32'h00000283;
  localparam logic [31:0] I_LH   = 32'h00001283;
  localparam logic [31:0] I_LW   = 32'h00002283;
  localparam logic [31:0] I_LD   = 32'h00003283;
  localparam logic [31:0] I_LBU  = 32'h00004283;
  localparam logic [31:0] I_SB   = 32'h00000023;
  localparam logic [31:0] I_SH   = 32'h00001023;

  initial begin
    rst = 1'b1; exu_valid = 1'b0; exu_addr = '0; exu_wdata = '0; exu_rd_data = '0;
    exu_inst = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; wbu_ready = 1'b0;
    tick(); tick();
    chk("rst_exu_ready", 32'(exu_ready), 32'd0);
    chk("rst_wbu_valid", 32'(wbu_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ls_count", ls_count, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_exu_ready", 32'(exu_ready), 32'd1);

    // Pass-through
    issue(I_ADDI, 32'h0, 32'h0, 32'h1234);
    chk("addi_valid", 32'(wbu_valid), 32'd1);
    chk("addi_rd", wbu_rd_data, 32'h1234);
    chk("addi_inst", wbu_inst, I_ADDI);
    chk("addi_no_req", 32'(mem_req), 32'd0);
    chk("addi_err", 32'(lsu_err), 32'd0);
    // Retire with a new instruction waiting: not accepted until IDLE
    exu_valid = 1'b1; exu_inst = I_ADDI; exu_rd_data = 32'h5678; wbu_ready = 1'b1;
    tick();
    wbu_ready = 1'b0;
    chk("retire_only_valid", 32'(wbu_valid), 32'd0);
    chk("retire_only_ready", 32'(exu_ready), 32'd1);
    tick();
    exu_valid = 1'b0;
    chk("next_accept_rd", wbu_rd_data, 32'h5678);
    retire();
    chk("addi_count", ls_count, 32'd0);

    // LB sign-extended byte lane 3
    issue(I_LB, 32'h80000003, 32'h0, 32'h0);
    chk("lb_req", 32'(mem_req), 32'd1);
    chk("lb_addr", mem_addr, 32'h80000000);
    chk("lb_we", 32'(mem_we), 32'd0);
    chk("lb_wstrb", 32'(mem_wstrb), 32'd0);
    gnt_then_rsp(32'h80FF0000);
    chk("lb_valid", 32'(wbu_valid), 32'd1);
    chk("lb_rd", wbu_rd_data, 32'hFFFFFF80);
    retire();
    chk("lb_count", ls_count, 32'd1);

    issue(I_LBU, 32'h80000003, 32'h0, 32'h0);
    gnt_then_rsp(32'h80FF0000);
    chk("lbu_rd", wbu_rd_data, 32'h00000080);
    retire();

    issue(I_LH, 32'h00000102, 32'h0, 32'h0);
    gnt_then_rsp(32'h80011234);
    chk("lh_rd", wbu_rd_data, 32'hFFFF8001);
    retire();

    // Stores
    issue(I_SH, 32'h10000002, 32'hDEADBEEF, 32'h0);
    chk("sh_we", 32'(mem_we), 32'd1);
    chk("sh_addr", mem_addr, 32'h10000000);
    chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hBEEFBEEF);
    gnt_then_rsp(32'h12345678);
    chk("sh_rd", wbu_rd_data, 32'h0);
    retire();
    chk("sh_count", ls_count, 32'd4);

    issue(I_SB, 32'h10000001, 32'h000000A5, 32'h0);
    chk("sb_wstrb", 32'(mem_wstrb), 32'h2);
    chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
    gnt_then_rsp(32'h0);
    retire();

    // Misaligned and unsupported: no bus access, not counted
    issue(I_LW, 32'h10000001, 32'h0, 32'h9999);
    chk("lw_mis_req", 32'(mem_req), 32'd0);
    chk("lw_mis_valid", 32'(wbu_valid), 32'd1);
    chk("lw_mis_err", 32'(lsu_err), 32'd1);
    chk("lw_mis_rd", wbu_rd_data, 32'h0);
    retire();
    chk("lw_mis_count", ls_count, 32'd5);
    issue(I_LD, 32'h0, 32'h0, 32'h0);
    chk("ld_unsup_err", 32'(lsu_err), 32'd1);
    retire();
    chk("ld_unsup_count", ls_count, 32'd5);

    // Stalled grant, delayed response, stalled WBU
    issue(I_LW, 32'h20000004, 32'h0, 32'h0);
    chk("stall_err_clear", 32'(lsu_err), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", 32'(mem_req), 32'd1);
      chk("stall_addr", mem_addr, 32'h20000004);
      chk("stall_exu_ready", 32'(exu_ready), 32'd0);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("wait_req", 32'(mem_req), 32'd0);
    tick();
    chk("wait_valid", 32'(wbu_valid), 32'd0);
    chk("wait_exu_ready", 32'(exu_ready), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      chk("hold_valid", 32'(wbu_valid), 32'd1);
      chk("hold_rd", wbu_rd_data, 32'hCAFEF00D);
      chk("hold_exu_ready", 32'(exu_ready), 32'd0);
      tick();
    end
    retire();
    chk("stall_done_valid", 32'(wbu_valid), 32'd0);
    chk("stall_done_ready", 32'(exu_ready), 32'd1);
    chk("stall_count", ls_count, 32'd6);

    // Grant and response together in REQ: response must come again in WAIT
    issue(I_LW, 32'h00000000, 32'h0, 32'h0);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("gnt_rsp_wait", 32'(wbu_valid), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
    tick();
    mem_rvalid = 1'b0;
    chk("gnt_rsp_rd", wbu_rd_data, 32'h22222222);
    retire();
    chk("gnt_rsp_count", ls_count, 32'd7);

    // Timeout on the TIMEOUT_CYC=4 instance
    rst = 1'b1; tick(); rst = 1'b0; tick();
    issue(I_LW, 32'h00000040, 32'h0, 32'h0);
    chk("to_req", 32'(t_mem_req), 32'd1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("to_pending", 32'(t_wbu_valid), 32'd0);
      if (i < 2) tick();
    end
    tick();
    chk("to_valid", 32'(t_wbu_valid), 32'd1);
    chk("to_err", 32'(t_lsu_err), 32'd1);
    chk("to_rd", t_wbu_rd_data, 32'h0);
    chk("to_default_waiting", 32'(wbu_valid), 32'd0);
    retire();
    chk("to_count", t_ls_count, 32'd0);

    // Reset in WAIT with a response landing; late response ignored
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick();
    chk("mid_rst_valid", 32'(wbu_valid), 32'd0);
    chk("mid_rst_ready", 32'(exu_ready), 32'd0);
    chk("mid_rst_rd", wbu_rd_data, 32'h0);
    chk("mid_rst_addr", mem_addr, 32'h0);
    chk("mid_rst_err", 32'(lsu_err), 32'd0);
    chk("mid_rst_count", ls_count, 32'd0);
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rsp_valid", 32'(wbu_valid), 32'd0);
    chk("late_rsp_ready", 32'(exu_ready), 32'd1);
    tick();
    chk("late_rsp_idle", 32'(wbu_valid), 32'd0);
    chk("late_rsp_req", 32'(mem_req), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
